// File: rtl/clock_pulse_scheduler.sv
// rtl/clock_pulse_scheduler.sv - processor clock-enable scheduler: free-run, halt and counted bursts
// Optional CYCLE_COUNTER_EN adds a 64-bit count of enabled cycles; otherwise cycle_count is tied to 0.
module clock_pulse_scheduler #(
  parameter int PULSE_BITS = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  input  logic                  write_pulse,
  input  logic [PULSE_BITS-1:0] num_pulses,
  input  logic                  cycle_count_clear,
  output logic                  proc_clk_en,
  output logic                  busy,
  output logic [PULSE_BITS-1:0] pulses_remaining,
  output logic                  burst_done,
  output logic                  pulse_rejected,
  output logic [63:0]           cycle_count
);

  typedef enum logic [1:0] {RUN, HALT, BURST} state_t;

  state_t                state, state_n;
  logic [PULSE_BITS-1:0] remaining_n;
  logic                  done_n;
  logic                  rejected_n;

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      pulses_remaining <= '0;
      burst_done       <= 1'b0;
      pulse_rejected   <= 1'b0;
    end else begin
      state            <= state_n;
      pulses_remaining <= remaining_n;
      burst_done       <= done_n;
      pulse_rejected   <= rejected_n;
    end
  end

  always_comb begin
    state_n     = state;
    remaining_n = pulses_remaining;
    done_n      = 1'b0;
    rejected_n  = 1'b0;
    case (state)
      RUN: begin
        rejected_n = write_pulse;
        if (!clk_enable) state_n = HALT;
      end
      HALT: begin
        // A free-run request outranks a burst request arriving in the same cycle.
        if (clk_enable) begin
          state_n    = RUN;
          rejected_n = write_pulse;
        end else if (write_pulse) begin
          if (num_pulses == '0) begin
            done_n = 1'b1;
          end else begin
            state_n     = BURST;
            remaining_n = num_pulses;
          end
        end
      end
      BURST: begin
        rejected_n = write_pulse;
        if (clk_enable) begin
          state_n     = RUN;
          remaining_n = '0;
        end else if (pulses_remaining == PULSE_BITS'(1)) begin
          state_n     = HALT;
          remaining_n = '0;
          done_n      = 1'b1;
        end else begin
          remaining_n = pulses_remaining - PULSE_BITS'(1);
        end
      end
      default: begin
        state_n     = RUN;
        remaining_n = '0;
      end
    endcase
  end

  assign proc_clk_en = (state != HALT);
  assign busy        = (state == BURST);

`ifdef CYCLE_COUNTER_EN
  logic [63:0] count_q;

  always_ff @(posedge clk) begin
    if (reset || cycle_count_clear) begin
      count_q <= '0;
    end else if (proc_clk_en) begin
      count_q <= count_q + 64'd1;
    end
  end

  assign cycle_count = count_q;
`else
  logic unused_clear;

  assign unused_clear = cycle_count_clear;
  assign cycle_count  = '0;
`endif

endmodule
